// File: rtl/tt_um_tdm_demux.sv
// TDM demultiplexer: aligns to a frame-sync marker on slot 0 and fans one serial bit per slot
// out to parallel channel outputs, publishing all channels together once per completed frame.
module tt_um_tdm_demux #(
    parameter int SLOTS       = 8,
    parameter int LOCK_FRAMES = 2
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {HUNT, ACQ, LOCK} state_t;

    localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);
    localparam logic [2:0] LOCK_LAST = 3'(LOCK_FRAMES - 1);
    localparam logic [7:0] CH_MASK   = 8'((1 << SLOTS) - 1);

    logic       data;
    logic       sync;
    logic       beat;
    logic       clr;
    logic       unused_inputs;

    state_t     state;
    logic [2:0] slot_cnt;
    logic [2:0] good_cnt;
    logic [7:0] shadow;
    logic [7:0] frame_word;
    logic       strobe;
    logic       err_pulse;
    logic       sticky;

    assign data = ui_in[0];
    assign sync = ui_in[1];
    assign beat = ena & ui_in[2];
    assign clr  = ena & ui_in[3];

    assign unused_inputs = ^{uio_in, ui_in[7:4]};

    assign uio_out = {4'b0000, err_pulse, sticky, (state == LOCK), strobe};
    assign uio_oe  = 8'h0F;

    // Shadow frame with the bit arriving this cycle merged in, so publish needs no extra cycle.
    always_comb begin
        frame_word           = shadow;
        frame_word[slot_cnt] = data;
        frame_word           = frame_word & CH_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            slot_cnt  <= 3'd0;
            good_cnt  <= 3'd0;
            shadow    <= 8'h00;
            uo_out    <= 8'h00;
            strobe    <= 1'b0;
            err_pulse <= 1'b0;
            sticky    <= 1'b0;
        end else begin
            strobe    <= 1'b0;
            err_pulse <= 1'b0;
            if (clr) begin
                sticky <= 1'b0;
            end
            if (beat) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            shadow[0] <= data;
                            slot_cnt  <= 3'd1;
                            good_cnt  <= 3'd0;
                            state     <= ACQ;
                        end
                    end
                    default: begin
                        if (sync && slot_cnt != 3'd0) begin
                            // Sync arrived early: treat this beat as the start of a fresh frame.
                            err_pulse <= 1'b1;
                            sticky    <= 1'b1;
                            shadow[0] <= data;
                            slot_cnt  <= 3'd1;
                            good_cnt  <= 3'd0;
                            state     <= ACQ;
                        end else if (!sync && slot_cnt == 3'd0) begin
                            err_pulse <= 1'b1;
                            sticky    <= 1'b1;
                            slot_cnt  <= 3'd0;
                            good_cnt  <= 3'd0;
                            state     <= HUNT;
                        end else begin
                            shadow[slot_cnt] <= data;
                            if (slot_cnt == LAST_SLOT) begin
                                slot_cnt <= 3'd0;
                                if (state == LOCK) begin
                                    uo_out <= frame_word;
                                    strobe <= 1'b1;
                                end else if (good_cnt == LOCK_LAST) begin
                                    state  <= LOCK;
                                    uo_out <= frame_word;
                                    strobe <= 1'b1;
                                end else begin
                                    good_cnt <= good_cnt + 3'd1;
                                end
                            end else begin
                                slot_cnt <= slot_cnt + 3'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_um_tdm_demux.sv
// Self-checking bench for tt_um_tdm_demux: every cycle is compared against a queue-based
// frame model, with extra fixed-value checks at the scenario boundaries.
module tb_tt_um_tdm_demux;

    localparam int SLOTS       = 8;
    localparam int LOCK_FRAMES = 2;

    typedef struct packed {
        logic d;
        logic s;
        logic v;
        logic c;
        logic e;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    beat_t stim[$];

    logic [7:0] m_out;
    logic       m_strobe;
    logic       m_err;
    logic       m_sticky;
    logic       m_locked;
    logic       m_aligned;
    int         m_good;
    bit         m_bits[$];

    always #5 clk = ~clk;

    tt_um_tdm_demux #(.SLOTS(SLOTS), .LOCK_FRAMES(LOCK_FRAMES)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic beat_t mk(input logic d, input logic s, input logic v, input logic c, input logic e);
        beat_t b;
        b.d = d; b.s = s; b.v = v; b.c = c; b.e = e;
        return b;
    endfunction

    function automatic logic [23:0] expected_pins();
        return {8'h0F, 4'h0, m_err, m_sticky, m_locked, m_strobe, m_out};
    endfunction

    task automatic model_reset();
        m_out = 8'h00; m_strobe = 0; m_err = 0; m_sticky = 0;
        m_locked = 0; m_aligned = 0; m_good = 0;
        m_bits.delete();
    endtask

    // Frame model: collects bits of the current frame in a queue; a full queue is a completed frame.
    task automatic model_step(input beat_t b);
        m_strobe = 0;
        m_err = 0;
        if (b.e && b.c) m_sticky = 0;
        if (b.e && b.v) begin
            if (!m_aligned) begin
                if (b.s) begin
                    m_bits.delete(); m_bits.push_back(b.d);
                    m_aligned = 1; m_good = 0;
                end
            end else if (b.s && m_bits.size() != 0) begin
                m_err = 1; m_locked = 0; m_good = 0;
                m_bits.delete(); m_bits.push_back(b.d);
            end else if (!b.s && m_bits.size() == 0) begin
                m_err = 1; m_locked = 0; m_good = 0; m_aligned = 0;
            end else begin
                m_bits.push_back(b.d);
                if (m_bits.size() == SLOTS) begin
                    m_good++;
                    if (m_good >= LOCK_FRAMES) m_locked = 1;
                    if (m_locked) begin
                        m_out = 8'h00;
                        for (int k = 0; k < SLOTS; k++) m_out[k] = m_bits[k];
                        m_strobe = 1;
                    end
                    m_bits.delete();
                end
            end
        end
        if (m_err) m_sticky = 1;
    endtask

    task automatic drive(input beat_t b);
        @(negedge clk);
        ui_in  = {4'($urandom), b.c, b.v, b.s, b.d};
        uio_in = 8'($urandom);
        ena    = b.e;
        @(posedge clk);
        model_step(b);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        ui_in = 8'h00;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic queue_frame(input logic [7:0] word, input bit gapped);
        for (int i = 0; i < SLOTS; i++) begin
            if (gapped) stim.push_back(mk(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1));
            stim.push_back(mk(word[i], i == 0, 1'b1, 1'b0, 1'b1));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({uio_oe, uio_out, uo_out} !== 24'h0F0000) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %h want %h", {uio_oe, uio_out, uo_out}, 24'h0F0000);
        end
        apply_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({uio_oe, uio_out, uo_out} !== 24'h0F0000) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h want %h", {uio_oe, uio_out, uo_out}, 24'h0F0000);
        end
    endtask

    task automatic test_clean();
        int strobes = 0;
        apply_reset();
        stim.delete();
        repeat (3) queue_frame(8'hA5, 1'b0);
        repeat (4) queue_frame(8'($urandom), 1'b0);
        foreach (stim[i]) begin
            drive(stim[i]);
            if (i < 3 * SLOTS && uio_out[0]) strobes++;
            if (i == 2 * SLOTS - 1) begin
                checks++;
                if ({uio_out[1:0], uo_out} !== {2'b11, 8'hA5}) begin
                    errors++;
                    $display("[TB] FAIL clean_first_lock: got %h want %h", {uio_out[1:0], uo_out}, {2'b11, 8'hA5});
                end
            end
            checks++;
            if ({uio_oe, uio_out, uo_out} !== expected_pins()) begin
                errors++;
                $display("[TB] FAIL clean beat %0d: got %h want %h", i, {uio_oe, uio_out, uo_out}, expected_pins());
            end
        end
        checks++;
        if (strobes !== 2) begin
            errors++;
            $display("[TB] FAIL clean_strobe_count: got %0d want %0d", strobes, 2);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] w = 8'($urandom);
        apply_reset();
        stim.delete();
        repeat (3) queue_frame(w, 1'b1);
        foreach (stim[i]) begin
            drive(stim[i]);
            checks++;
            if ({uio_oe, uio_out, uo_out} !== expected_pins()) begin
                errors++;
                $display("[TB] FAIL gapped beat %0d: got %h want %h", i, {uio_oe, uio_out, uo_out}, expected_pins());
            end
        end
        checks++;
        if (uo_out !== w) begin
            errors++;
            $display("[TB] FAIL gapped_word: got %h want %h", uo_out, w);
        end
    endtask

    task automatic test_misaligned();
        int err_idx;
        logic [7:0] a5 = 8'hA5;
        logic [7:0] c3 = 8'h3C;
        apply_reset();
        stim.delete();
        repeat (2) queue_frame(8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) stim.push_back(mk(a5[k], k == 0, 1'b1, 1'b0, 1'b1));
        err_idx = stim.size();
        stim.push_back(mk(c3[0], 1'b1, 1'b1, 1'b0, 1'b1));
        for (int k = 1; k < SLOTS; k++) stim.push_back(mk(c3[k], 1'b0, 1'b1, 1'b0, 1'b1));
        queue_frame(8'h3C, 1'b0);
        foreach (stim[i]) begin
            drive(stim[i]);
            if (i == err_idx) begin
                checks++;
                if ({uio_out[3:0], uo_out} !== {4'b1100, 8'hA5}) begin
                    errors++;
                    $display("[TB] FAIL misaligned_event: got %h want %h", {uio_out[3:0], uo_out}, {4'b1100, 8'hA5});
                end
            end
            checks++;
            if ({uio_oe, uio_out, uo_out} !== expected_pins()) begin
                errors++;
                $display("[TB] FAIL misaligned beat %0d: got %h want %h", i, {uio_oe, uio_out, uo_out}, expected_pins());
            end
        end
        checks++;
        if ({uio_out[1], uo_out} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("[TB] FAIL misaligned_relock: got %h want %h", {uio_out[1], uo_out}, {1'b1, 8'h3C});
        end
    endtask

    task automatic test_missing_sync();
        int miss_idx;
        apply_reset();
        stim.delete();
        repeat (2) queue_frame(8'hA5, 1'b0);
        miss_idx = stim.size();
        stim.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
        repeat (3) stim.push_back(mk(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b1));
        repeat (2) queue_frame(8'h5A, 1'b0);
        stim.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        stim.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        stim.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        stim.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        foreach (stim[i]) begin
            drive(stim[i]);
            if (i == miss_idx) begin
                checks++;
                if ({uio_out[3:0], uo_out} !== {4'b1100, 8'hA5}) begin
                    errors++;
                    $display("[TB] FAIL missing_event: got %h want %h", {uio_out[3:0], uo_out}, {4'b1100, 8'hA5});
                end
            end
            if (i == stim.size() - 3) begin
                checks++;
                if ({uio_out[2], uo_out} !== {1'b0, 8'h5A}) begin
                    errors++;
                    $display("[TB] FAIL sticky_clear: got %h want %h", {uio_out[2], uo_out}, {1'b0, 8'h5A});
                end
            end
            checks++;
            if ({uio_oe, uio_out, uo_out} !== expected_pins()) begin
                errors++;
                $display("[TB] FAIL missing beat %0d: got %h want %h", i, {uio_oe, uio_out, uo_out}, expected_pins());
            end
        end
        checks++;
        if (uio_out[3:2] !== 2'b11) begin
            errors++;
            $display("[TB] FAIL sticky_set_wins: got %b want %b", uio_out[3:2], 2'b11);
        end
    endtask

    task automatic test_reset_ena();
        logic [7:0] w = 8'h96;
        apply_reset();
        stim.delete();
        repeat (2) queue_frame(8'hA5, 1'b0);
        for (int k = 0; k < 5; k++) stim.push_back(mk(w[k], k == 0, 1'b1, 1'b0, 1'b1));
        foreach (stim[i]) begin
            drive(stim[i]);
            checks++;
            if ({uio_oe, uio_out, uo_out} !== expected_pins()) begin
                errors++;
                $display("[TB] FAIL prereset beat %0d: got %h want %h", i, {uio_oe, uio_out, uo_out}, expected_pins());
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({uio_oe, uio_out, uo_out} !== 24'h0F0000) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h want %h", {uio_oe, uio_out, uo_out}, 24'h0F0000);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stim.delete();
        repeat (3) stim.push_back(mk(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b1));
        queue_frame(w, 1'b0);
        for (int k = 0; k < 4; k++) stim.push_back(mk(w[k], k == 0, 1'b1, 1'b0, 1'b1));
        repeat (10) stim.push_back(mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0));
        for (int k = 4; k < SLOTS; k++) stim.push_back(mk(w[k], 1'b0, 1'b1, 1'b0, 1'b1));
        foreach (stim[i]) begin
            drive(stim[i]);
            checks++;
            if ({uio_oe, uio_out, uo_out} !== expected_pins()) begin
                errors++;
                $display("[TB] FAIL ena beat %0d: got %h want %h", i, {uio_oe, uio_out, uo_out}, expected_pins());
            end
        end
        checks++;
        if ({uio_out[1], uo_out} !== {1'b1, 8'h96}) begin
            errors++;
            $display("[TB] FAIL ena_resume: got %h want %h", {uio_out[1], uo_out}, {1'b1, 8'h96});
        end
    endtask

    task automatic test_random();
        int pos = 0;
        apply_reset();
        stim.delete();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) begin
                stim.push_back(mk(1'($urandom), 1'($urandom), 1'b0, $urandom_range(19) == 0, 1'b1));
            end else if ($urandom_range(9) == 0) begin
                stim.push_back(mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0));
            end else begin
                stim.push_back(mk(1'($urandom), (pos == 0) ^ ($urandom_range(24) == 0), 1'b1,
                                  $urandom_range(29) == 0, 1'b1));
                pos = (pos + 1) % SLOTS;
            end
        end
        foreach (stim[i]) begin
            drive(stim[i]);
            checks++;
            if ({uio_oe, uio_out, uo_out} !== expected_pins()) begin
                errors++;
                $display("[TB] FAIL random beat %0d: got %h want %h", i, {uio_oe, uio_out, uo_out}, expected_pins());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean();
        test_gapped();
        test_misaligned();
        test_missing_sync();
        test_reset_ena();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
